// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - field codes, field sizes, fault codes and FSM states for processor_loader
package processor_pkg;

    localparam logic [2:0] CM_A      = 3'b000;
    localparam logic [2:0] CM_B      = 3'b001;
    localparam logic [2:0] CM_C      = 3'b010;
    localparam logic [2:0] CM_PAIR   = 3'b011;
    localparam logic [2:0] CM_MEM    = 3'b100;
    localparam logic [2:0] CM_COMMIT = 3'b101;
    localparam logic [2:0] CM_NOP    = 3'b111;

    localparam logic [2:0] LEN_A    = 3'd1;
    localparam logic [2:0] LEN_B    = 3'd1;
    localparam logic [2:0] LEN_C    = 3'd1;
    localparam logic [2:0] LEN_PAIR = 3'd2;
    localparam logic [2:0] LEN_MEM  = 3'd4;

    localparam logic [2:0] FAULT_TIMEOUT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_COMMIT,
        ST_WAIT_ASSIGN,
        ST_SELECT,
        ST_RUN,
        ST_FAULT
    } state_e;

    function automatic logic [2:0] field_len(input logic [2:0] code);
        logic [2:0] len;
        case (code)
            CM_A:    len = LEN_A;
            CM_B:    len = LEN_B;
            CM_C:    len = LEN_C;
            CM_PAIR: len = LEN_PAIR;
            CM_MEM:  len = LEN_MEM;
            default: len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/processor_loader_if.sv
// rtl/processor_loader_if.sv - host byte stream into the loader (valid/ready)
interface processor_loader_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/processor_loader_sequencer.sv
// rtl/processor_loader_sequencer.sv - load_sequencer: field/byte/hold counters for the image schedule
module load_sequencer
    import processor_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       clear,
    input  logic       hold_en,
    input  logic       step_en,
    output logic [2:0] field,
    output logic       hold_last,
    output logic       image_done
);

    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0] field_q, field_d;
    logic       field_done;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hold_cnt_q <= '0;
            byte_cnt_q <= '0;
            field_q    <= CM_A;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            field_q    <= field_d;
        end
    end

    always_comb begin
        hold_last  = hold_en && (hold_cnt_q == 4'(HOLD_CYCLES - 1));
        field_done = ({1'b0, byte_cnt_q} == (field_len(field_q) - 3'd1));
        image_done = field_done && (field_q == CM_MEM);

        hold_cnt_d = hold_cnt_q + 4'd1;
        if (!hold_en || hold_last) begin
            hold_cnt_d = '0;
        end

        byte_cnt_d = byte_cnt_q;
        field_d    = field_q;
        if (clear) begin
            byte_cnt_d = '0;
            field_d    = CM_A;
        end else if (step_en && hold_last) begin
            // After the memory field the counter rests on CM_COMMIT until cleared.
            if (field_done) begin
                byte_cnt_d = '0;
                field_d    = field_q + 3'd1;
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
    end

    assign field = field_q;

endmodule

// File: rtl/processor_loader.sv
// rtl/processor_loader.sv - streams a 9-byte image onto the processor load port, then starts and supervises it
module processor_loader
    import processor_pkg::*;
#(
    parameter int HOLD_CYCLES    = 2,
    parameter int ASSIGN_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               start,
    input  logic [2:0]         out_sel,
    processor_loader_if.slave  s_if,
    output logic [2:0]         control_mem,
    output logic [7:0]         proc_data,
    output logic [2:0]         proc_control_out,
    output logic               proc_enable,
    input  logic               memory_assign,
    input  logic [2:0]         error,
    output logic               busy,
    output logic               running,
    output logic               fault,
    output logic [2:0]         fault_code
);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] timer_q, timer_d;

    logic [2:0] control_mem_q, control_mem_d;
    logic [7:0] proc_data_q, proc_data_d;
    logic [2:0] pcout_q, pcout_d;
    logic       proc_enable_q, proc_enable_d;
    logic       s_ready_q, s_ready_d;
    logic       busy_q, busy_d;
    logic       running_q, running_d;
    logic       fault_q, fault_d;
    logic [2:0] fault_code_q, fault_code_d;

    logic [2:0] field;
    logic       hold_last;
    logic       image_done;
    logic       xfer;
    logic       seq_clear;
    logic       seq_hold_en;
    logic       seq_step_en;

    assign xfer        = (state_q == ST_FETCH) && s_ready_q && s_if.s_valid;
    assign seq_clear   = (state_q == ST_IDLE);
    assign seq_hold_en = (state_q == ST_HOLD) || (state_q == ST_COMMIT);
    assign seq_step_en = (state_q == ST_HOLD);

    load_sequencer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_seq (
        .clk        (clk),
        .reset_b    (reset_b),
        .clear      (seq_clear),
        .hold_en    (seq_hold_en),
        .step_en    (seq_step_en),
        .field      (field),
        .hold_last  (hold_last),
        .image_done (image_done)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            timer_q       <= '0;
            control_mem_q <= CM_NOP;
            proc_data_q   <= '0;
            pcout_q       <= '0;
            proc_enable_q <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            running_q     <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            timer_q       <= timer_d;
            control_mem_q <= control_mem_d;
            proc_data_q   <= proc_data_d;
            pcout_q       <= pcout_d;
            proc_enable_q <= proc_enable_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            running_q     <= running_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = (state_q == ST_WAIT_ASSIGN) ? timer_q + 8'd1 : 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    sel_d   = out_sel;
                end
            end
            ST_FETCH: begin
                if (xfer) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_last) state_d = image_done ? ST_COMMIT : ST_FETCH;
            end
            ST_COMMIT: begin
                if (hold_last) state_d = ST_WAIT_ASSIGN;
            end
            ST_WAIT_ASSIGN: begin
                if (memory_assign) begin
                    state_d = ST_SELECT;
                end else if (timer_q == 8'(ASSIGN_TIMEOUT - 1)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_SELECT: state_d = ST_RUN;
            ST_RUN: begin
                // A processor fault wins over a simultaneous restart request.
                if (error != 3'b000) begin
                    state_d = ST_FAULT;
                end else if (start) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with the state it belongs to.
    always_comb begin
        control_mem_d = CM_NOP;
        if (state_d == ST_HOLD) begin
            control_mem_d = field;
        end else if (state_d == ST_COMMIT) begin
            control_mem_d = CM_COMMIT;
        end

        proc_data_d = proc_data_q;
        if (xfer) begin
            proc_data_d = s_if.s_data;
        end else if (state_d == ST_COMMIT) begin
            proc_data_d = 8'h00;
        end

        pcout_d       = (state_d == ST_SELECT) ? sel_q : pcout_q;
        proc_enable_d = (state_d == ST_RUN);
        running_d     = (state_d == ST_RUN);
        s_ready_d     = (state_d == ST_FETCH);
        busy_d        = (state_d == ST_FETCH) || (state_d == ST_HOLD) || (state_d == ST_COMMIT) ||
                        (state_d == ST_WAIT_ASSIGN) || (state_d == ST_SELECT);
        fault_d       = (state_d == ST_FAULT);

        fault_code_d = fault_code_q;
        if (state_q == ST_IDLE && start) begin
            fault_code_d = 3'b000;
        end else if (state_q == ST_WAIT_ASSIGN && state_d == ST_FAULT) begin
            fault_code_d = FAULT_TIMEOUT;
        end else if (state_q == ST_RUN && state_d == ST_FAULT) begin
            fault_code_d = error;
        end
    end

    assign control_mem      = control_mem_q;
    assign proc_data        = proc_data_q;
    assign proc_control_out = pcout_q;
    assign proc_enable      = proc_enable_q;
    assign s_if.s_ready     = s_ready_q;
    assign busy             = busy_q;
    assign running          = running_q;
    assign fault            = fault_q;
    assign fault_code       = fault_code_q;

endmodule

// File: tb/tb_processor_loader.sv
// tb/tb_processor_loader.sv - scoreboard bench for processor_loader
module tb_processor_loader;

    localparam int HOLD = 2;
    localparam int TMO  = 64;

    logic       clk;
    logic       reset_b;
    logic       start;
    logic [2:0] out_sel;
    logic [2:0] control_mem;
    logic [7:0] proc_data;
    logic [2:0] proc_control_out;
    logic       proc_enable;
    logic       memory_assign;
    logic [2:0] error;
    logic       busy;
    logic       running;
    logic       fault;
    logic [2:0] fault_code;

    processor_loader_if s_if();

    processor_loader #(
        .HOLD_CYCLES    (HOLD),
        .ASSIGN_TIMEOUT (TMO)
    ) dut (
        .clk              (clk),
        .reset_b          (reset_b),
        .start            (start),
        .out_sel          (out_sel),
        .s_if             (s_if),
        .control_mem      (control_mem),
        .proc_data        (proc_data),
        .proc_control_out (proc_control_out),
        .proc_enable      (proc_enable),
        .memory_assign    (memory_assign),
        .error            (error),
        .busy             (busy),
        .running          (running),
        .fault            (fault),
        .fault_code       (fault_code)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [7:0]  tx_q[$];
    logic [10:0] exp_q[$];
    int          byte_idx   = 0;
    int          stall_idx  = -1;
    int          stall_left = 0;

    logic [7:0] img [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04, 8'h08, 8'h0C, 8'h0D};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic logic [2:0] field_of(input int idx);
        if (idx < 3) return 3'(idx);
        else if (idx < 5) return 3'b011;
        else return 3'b100;
    endfunction

    // Host stream driver: each accepted byte queues its expected load-port cycles.
    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (reset_b && s_if.s_valid && s_if.s_ready && tx_q.size() > 0) begin
                logic [7:0] b;
                b = tx_q.pop_front();
                for (int h = 0; h < HOLD; h++) exp_q.push_back({field_of(byte_idx), b});
                byte_idx++;
                if (byte_idx == 9)
                    for (int h = 0; h < HOLD; h++) exp_q.push_back({3'b101, 8'h00});
            end
            #1;
            if (stall_left > 0 && byte_idx == stall_idx) begin
                stall_left--;
                s_if.s_valid = 1'b0;
            end else begin
                s_if.s_valid = (tx_q.size() > 0);
                s_if.s_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
            end
        end
    end

    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (reset_b && control_mem != 3'b111) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_code", control_mem, 7);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_code", control_mem, e[10:8]);
                    check_eq("sb_data", proc_data, e[7:0]);
                end
            end
        end
    end

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_control_mem"}, control_mem, 7);
        check_eq({pfx, "_proc_data"}, proc_data, 0);
        check_eq({pfx, "_pcout"}, proc_control_out, 0);
        check_eq({pfx, "_enable"}, proc_enable, 0);
        check_eq({pfx, "_s_ready"}, s_if.s_ready, 0);
        check_eq({pfx, "_busy"}, busy, 0);
        check_eq({pfx, "_running"}, running, 0);
        check_eq({pfx, "_fault"}, fault, 0);
        check_eq({pfx, "_fault_code"}, fault_code, 0);
    endtask

    task automatic pulse_start(input logic [2:0] sel);
        start   = 1'b1;
        out_sel = sel;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // dly: cycles into WAIT_ASSIGN before memory_assign (0 = already high, <0 = never).
    task automatic run_image(input logic [2:0] sel, input int dly, input int lat,
                             input int nop_exp, input bit ign, input bit rnd);
        int t0, w, nop, early;
        bit seen, found, ign_done;
        byte_idx = 0;
        for (int i = 0; i < 9; i++) tx_q.push_back(rnd ? 8'($urandom_range(0, 255)) : img[i]);
        memory_assign = (dly == 0);
        @(negedge clk);
        start   = 1'b1;
        out_sel = sel;
        t0      = cyc;
        @(negedge clk);
        start = 1'b0;
        seen = 0; found = 0; ign_done = 0; nop = 0; w = 0; early = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (i > 0) begin
                @(negedge clk);
                start   = 1'b0;
                out_sel = sel;
            end
            if (seen && control_mem == 3'b111) begin
                found = 1;
                w     = cyc;
            end else begin
                if (control_mem == 3'b101) seen = 1;
                if (!seen && control_mem == 3'b111) nop++;
                if (ign && !ign_done && control_mem == 3'b010) begin
                    start    = 1'b1;
                    out_sel  = ~sel;
                    ign_done = 1;
                end
            end
        end
        check_eq("wait_assign_reached", found, 1);
        check_eq("load_latency", w - t0 - 1, lat);
        check_eq("fetch_nop_cycles", nop, nop_exp);
        check_eq("sb_drain", exp_q.size(), 0);
        check_eq("busy_in_wait", busy, 1);
        check_eq("ign_start_applied", ign_done, ign);
        if (dly < 0) begin
            error = 3'b011;
            for (int i = 1; i < TMO; i++) begin
                @(negedge clk);
                if (fault || proc_enable) early++;
            end
            @(negedge clk);
            check_eq("timeout_early", early, 0);
            check_eq("timeout_fault", fault, 1);
            check_eq("timeout_code", fault_code, 7);
            check_eq("timeout_enable", proc_enable, 0);
            check_eq("timeout_busy", busy, 0);
            error = 3'b000;
        end else begin
            if (dly > 0) begin
                repeat (dly - 1) @(negedge clk);
                memory_assign = 1'b1;
            end
            @(negedge clk);
            memory_assign = 1'b0;
            check_eq("select_pcout", proc_control_out, sel);
            check_eq("select_enable", proc_enable, 0);
            check_eq("select_busy", busy, 1);
            @(negedge clk);
            check_eq("run_enable", proc_enable, 1);
            check_eq("run_running", running, 1);
            check_eq("run_busy", busy, 0);
        end
    endtask

    task automatic abort_run(input string pfx);
        pulse_start(3'b111);
        check_eq({pfx, "_abort_enable"}, proc_enable, 0);
        check_eq({pfx, "_abort_running"}, running, 0);
        check_eq({pfx, "_abort_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        bit hit;
        reset_b       = 1'b0;
        start         = 1'b0;
        out_sel       = 3'b000;
        memory_assign = 1'b0;
        error         = 3'b000;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_b = 1'b1;
        @(negedge clk);

        run_image(3'b000, 3, 9 * (1 + HOLD) + HOLD, 9, 0, 0);
        abort_run("nominal");

        stall_idx  = 4;
        stall_left = 5;
        run_image(3'b011, 3, 9 * (1 + HOLD) + HOLD + 3, 12, 0, 0);
        check_eq("stall_consumed", stall_left, 0);
        abort_run("stall");

        run_image(3'b101, 1, 9 * (1 + HOLD) + HOLD, 9, 1, 1);
        abort_run("ignore");

        run_image(3'b001, -1, 9 * (1 + HOLD) + HOLD, 9, 0, 1);
        check_eq("pcout_keeps_last", proc_control_out, 3'b101);
        pulse_start(3'b000);
        check_eq("timeout_fault_cleared", fault, 0);

        run_image(3'b110, 0, 9 * (1 + HOLD) + HOLD, 9, 0, 1);
        error = 3'b010;
        @(negedge clk);
        error = 3'b000;
        check_eq("err_enable", proc_enable, 0);
        check_eq("err_fault", fault, 1);
        check_eq("err_code", fault_code, 2);
        check_eq("err_running", running, 0);
        pulse_start(3'b000);
        check_eq("err_fault_cleared", fault, 0);
        check_eq("err_enable_after", proc_enable, 0);

        byte_idx = 0;
        for (int i = 0; i < 9; i++) tx_q.push_back(img[i]);
        @(negedge clk);
        pulse_start(3'b010);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (control_mem == 3'b100) hit = 1;
        end
        check_eq("rst_reach_mem", hit, 1);
        #1 reset_b = 1'b0;
        tx_q.delete();
        exp_q.delete();
        byte_idx = 0;
        #1 check_reset_vals("rst_mid");
        @(posedge clk);
        #1 reset_b = 1'b1;
        run_image(3'b010, 2, 9 * (1 + HOLD) + HOLD, 9, 0, 1);
        abort_run("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
